// File: rtl/serial_packet_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkg
// Description : Shared types, default parameters and the parity helper for
//               the serial packet receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_pkg;

    typedef enum logic [2:0] {
        HUNT = 3'b001,
        READ = 3'b010,
        PAR  = 3'b100
    } state_t;

    localparam int         c_def_pkt_w    = 55;
    localparam int         c_def_sync_w   = 6;
    localparam logic [5:0] c_def_sync_pat = 6'b011111;

    // Even parity: accumulated payload parity plus the parity bit must be 0.
    function automatic logic parity_ok(input logic acc, input logic par_bit);
        return (acc ^ par_bit) == 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_packet_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_packet_rx_if
// Description : Serial input and held valid/ready packet output of the
//               serial packet receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_packet_rx_if
    import rx_pkg::*;
#(
    parameter int PKT_W = c_def_pkt_w
);
    logic             s_data;
    logic [PKT_W-1:0] pkt;
    logic             pkt_valid;
    logic             pkt_ready;
    logic             parity_err;
    logic             overrun;

    modport master (
        input  s_data,
        input  pkt_ready,
        output pkt,
        output pkt_valid,
        output parity_err,
        output overrun
    );

    modport slave (
        output s_data,
        output pkt_ready,
        input  pkt,
        input  pkt_valid,
        input  parity_err,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/serial_packet_rx_sync_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_detect
// Description : Sync pattern hunter; flags a match on the bit being sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_detect
    import rx_pkg::*;
#(
    parameter int              SYNC_W   = c_def_sync_w,
    parameter logic [SYNC_W-1:0] SYNC_PAT = c_def_sync_pat
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_shift_en,
    input  wire  i_reload,
    input  wire  i_s_data,
    output logic o_match
);
    localparam logic [SYNC_W-1:0] c_inv_pat = ~SYNC_PAT;

    // Only the newest SYNC_W-1 history bits affect a match; the oldest bit of
    // the pattern-wide register is shifted out before it is ever compared.
    logic [SYNC_W-2:0] r_hist;
    logic [SYNC_W-1:0] w_next;

    assign w_next  = {r_hist, i_s_data};
    assign o_match = i_shift_en && (w_next == SYNC_PAT);

    always_ff @(posedge clk) begin
        if (rst || i_reload) begin
            r_hist <= c_inv_pat[SYNC_W-2:0];
        end else if (i_shift_en) begin
            r_hist <= w_next[SYNC_W-2:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/serial_packet_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_packet_rx
// Description : Sync-hunting serial packet receiver with optional even parity
//               and a held valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_packet_rx
    import rx_pkg::*;
#(
    parameter int                PKT_W     = c_def_pkt_w,
    parameter int                SYNC_W    = c_def_sync_w,
    parameter logic [SYNC_W-1:0] SYNC_PAT  = c_def_sync_pat,
    parameter bit                PARITY_EN = 1'b1
) (
    input wire                 clk,
    input wire                 rst,
    serial_packet_rx_if.master bus
);
    localparam int c_cnt_w = (PKT_W > 1) ? $clog2(PKT_W) : 1;

    generate
        if (PKT_W < 2) begin : g_bad_pkt_w
            $error("serial_packet_rx: PKT_W must be at least 2");
        end
        if (SYNC_W < 2 || SYNC_W > 16) begin : g_bad_sync_w
            $error("serial_packet_rx: SYNC_W must be in 2..16");
        end
        if (SYNC_PAT == {SYNC_W{1'b1}} || SYNC_PAT == {SYNC_W{1'b0}}) begin : g_bad_sync_pat
            $error("serial_packet_rx: SYNC_PAT must not be all-ones or all-zeros");
        end
    endgenerate

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [PKT_W-1:0]   r_shift;
    logic               r_acc;
    logic [PKT_W-1:0]   r_pkt;
    logic               r_pkt_valid;
    logic               r_parity_err;
    logic               r_overrun;

    logic               w_match;
    logic               w_done;
    logic               w_good;
    logic               w_free;
    logic [PKT_W-1:0]   w_payload;

    sync_detect #(
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_sync_detect (
        .clk        (clk),
        .rst        (rst),
        .i_shift_en (r_state == HUNT),
        .i_reload   (w_done),
        .i_s_data   (bus.s_data),
        .o_match    (w_match)
    );

    // Completion happens on the last payload edge without parity, or on the
    // parity edge; the payload must then include the bit sampled this edge.
    always_comb begin
        w_done    = 1'b0;
        w_good    = 1'b0;
        w_payload = r_shift;
        case (r_state)
            READ: begin
                if (r_cnt == '0 && !PARITY_EN) begin
                    w_done    = 1'b1;
                    w_good    = 1'b1;
                    w_payload = {r_shift[PKT_W-2:0], bus.s_data};
                end
            end
            PAR: begin
                w_done = 1'b1;
                w_good = parity_ok(r_acc, bus.s_data);
            end
            default: ;
        endcase
    end

    assign w_free = !r_pkt_valid || bus.pkt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HUNT;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_acc        <= 1'b0;
            r_pkt        <= '0;
            r_pkt_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            if (r_pkt_valid && bus.pkt_ready) begin
                r_pkt_valid <= 1'b0;
            end

            case (r_state)
                HUNT: begin
                    if (w_match) begin
                        r_state <= READ;
                        r_cnt   <= c_cnt_w'(PKT_W - 1);
                        r_acc   <= 1'b0;
                    end
                end
                READ: begin
                    r_shift <= {r_shift[PKT_W-2:0], bus.s_data};
                    r_acc   <= r_acc ^ bus.s_data;
                    if (r_cnt == '0) begin
                        r_state <= PARITY_EN ? PAR : HUNT;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                PAR:     r_state <= HUNT;
                default: r_state <= HUNT;
            endcase

            // A load on the same edge as an accept overrides the clear above.
            if (w_done) begin
                if (!w_good) begin
                    r_parity_err <= 1'b1;
                end else if (w_free) begin
                    r_pkt       <= w_payload;
                    r_pkt_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign bus.pkt        = r_pkt;
    assign bus.pkt_valid  = r_pkt_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_serial_packet_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_packet_rx
// Description : Directed self-checking bench for serial_packet_rx (default
//               configuration plus an 8-bit, no-parity configuration).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_packet_rx;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_perr   = 0;
    int   n_ovr    = 0;

    logic [54:0] pay_a = 55'h2A_5555_AAAA_5555;
    logic [54:0] pay_b = 55'h12_3456_789A_BCDE;
    logic [54:0] pay_c = 55'h7F_0000_0000_0001;
    logic [54:0] pay_s = 55'h40_02F8_0000_0003;   // 011111 at bits [40:35]
    logic [54:0] pay_t = 55'h15_5555_5555_5555;   // no run of five ones
    int          e_perr;
    int          e_ovr;

    always #5 clk = ~clk;

    serial_packet_rx_if #(.PKT_W(55)) bus ();
    serial_packet_rx_if #(.PKT_W(8))  bus_alt ();

    serial_packet_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_packet_rx #(
        .PKT_W     (8),
        .SYNC_W    (4),
        .SYNC_PAT  (4'b0110),
        .PARITY_EN (1'b0)
    ) dut_alt (
        .clk (clk),
        .rst (rst),
        .bus (bus_alt)
    );

    always @(negedge clk) begin
        if (bus.parity_err) n_perr <= n_perr + 1;
        if (bus.overrun)    n_ovr  <= n_ovr + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.s_data = v[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_alt(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus_alt.s_data = v[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_head(input logic [54:0] p);
        send_bits(64'(6'b011111), 6);
        send_bits(64'(p), 55);
    endtask

    task automatic send_frame(input logic [54:0] p);
        send_head(p);
        send_bits(64'(^p), 1);
    endtask

    task automatic consume();
        bus.pkt_ready = 1'b1;
        send_bits(64'd0, 1);
        bus.pkt_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        bus.s_data        = 1'b0;
        bus.pkt_ready     = 1'b0;
        bus_alt.s_data    = 1'b0;
        bus_alt.pkt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  64'(bus.pkt_valid),  64'd0);
        chk("rst_pkt",    64'(bus.pkt),        64'd0);
        chk("rst_perr",   64'(bus.parity_err), 64'd0);
        chk("rst_ovr",    64'(bus.overrun),    64'd0);
        chk("rst_alt_v",  64'(bus_alt.pkt_valid), 64'd0);
        rst = 1'b0;
        send_bits(64'd0, 2);

        // Good packet: valid only after the parity edge, held until accepted.
        send_head(pay_a);
        chk("good_pre_par_valid", 64'(bus.pkt_valid), 64'd0);
        send_bits(64'd1, 1);   // parity of pay_a (27 ones)
        chk("good_valid", 64'(bus.pkt_valid), 64'd1);
        chk("good_pkt",   64'(bus.pkt),       64'(pay_a));
        send_bits(64'd0, 3);
        chk("good_hold_valid", 64'(bus.pkt_valid), 64'd1);
        chk("good_hold_pkt",   64'(bus.pkt),       64'(pay_a));
        consume();
        chk("good_accept_valid", 64'(bus.pkt_valid), 64'd0);

        // Bad parity: one-cycle pulse, nothing loaded, next frame fine.
        e_perr = n_perr;
        send_head(pay_a);
        send_bits(64'd0, 1);
        chk("perr_pulse", 64'(bus.parity_err), 64'd1);
        chk("perr_valid", 64'(bus.pkt_valid),  64'd0);
        send_bits(64'd0, 1);
        chk("perr_clear", 64'(bus.parity_err), 64'd0);
        chk("perr_count", 64'(n_perr - e_perr), 64'd1);
        send_frame(pay_b);
        chk("after_perr_valid", 64'(bus.pkt_valid), 64'd1);
        chk("after_perr_pkt",   64'(bus.pkt),       64'(pay_b));
        consume();

        // Overrun: two back-to-back frames with the consumer stalled.
        e_ovr = n_ovr;
        send_frame(pay_a);
        chk("ovr_first_pkt", 64'(bus.pkt), 64'(pay_a));
        chk("ovr_first_flag", 64'(bus.overrun), 64'd0);
        send_frame(pay_b);
        chk("ovr_pulse", 64'(bus.overrun),   64'd1);
        chk("ovr_pkt",   64'(bus.pkt),       64'(pay_a));
        chk("ovr_valid", 64'(bus.pkt_valid), 64'd1);
        send_head(pay_c);
        bus.pkt_ready = 1'b1;
        send_bits(64'(^pay_c), 1);
        bus.pkt_ready = 1'b0;
        chk("swap_ovr",   64'(bus.overrun),   64'd0);
        chk("swap_pkt",   64'(bus.pkt),       64'(pay_c));
        chk("swap_valid", 64'(bus.pkt_valid), 64'd1);
        send_bits(64'd0, 1);
        chk("swap_hold_valid", 64'(bus.pkt_valid), 64'd1);
        chk("ovr_count", 64'(n_ovr - e_ovr), 64'd1);
        consume();

        // Sync pattern inside the payload is not a resync point.
        send_frame(pay_s);
        chk("insync_valid", 64'(bus.pkt_valid), 64'd1);
        chk("insync_pkt",   64'(bus.pkt),       64'(pay_s));

        // Truncated sync: packet P stays held and no frame completes.
        e_perr = n_perr;
        e_ovr  = n_ovr;
        send_bits(64'(5'b01111), 5);
        send_bits(64'(pay_t), 55);
        send_bits(64'd0, 4);
        chk("trunc_pkt",  64'(bus.pkt), 64'(pay_s));
        chk("trunc_perr", 64'(n_perr - e_perr), 64'd0);
        chk("trunc_ovr",  64'(n_ovr - e_ovr),   64'd0);

        // Reset mid-payload with P still held.
        send_bits(64'(6'b011111), 6);
        send_bits(64'(pay_a[54:35]), 20);
        rst = 1'b1;
        send_bits(64'(pay_a[34]), 1);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(bus.pkt_valid),  64'd0);
        chk("mid_rst_pkt",   64'(bus.pkt),        64'd0);
        chk("mid_rst_perr",  64'(bus.parity_err), 64'd0);
        chk("mid_rst_ovr",   64'(bus.overrun),    64'd0);
        send_frame(pay_b);
        chk("post_rst_valid", 64'(bus.pkt_valid), 64'd1);
        chk("post_rst_pkt",   64'(bus.pkt),       64'(pay_b));
        consume();

        // Alternate configuration: 4-bit sync, 8-bit payload, no parity.
        send_alt(64'(4'b0110), 4);
        send_alt(64'(7'b1100001), 7);
        chk("alt_pre_valid", 64'(bus_alt.pkt_valid), 64'd0);
        send_alt(64'd1, 1);
        chk("alt_valid", 64'(bus_alt.pkt_valid), 64'd1);
        chk("alt_pkt",   64'(bus_alt.pkt),       64'h0C3);
        bus_alt.pkt_ready = 1'b1;
        send_alt(64'd0, 1);
        bus_alt.pkt_ready = 1'b0;
        chk("alt_accept_valid", 64'(bus_alt.pkt_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
